// File: rtl/factor_search_pkg.sv
// Shared types and search bounds for the sequential factor search engine.
package factor_search_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, MUL, CMP, DONE} state_t;

  localparam int A_WIDTH_DEF = 5;
  localparam int B_WIDTH_DEF = 3;
  localparam int A_MIN       = 2;
  localparam int B_MIN       = 2;
  localparam int A_MAX       = (1 << A_WIDTH_DEF) - 1;
  localparam int B_MAX       = (1 << B_WIDTH_DEF) - 1;

endpackage

// File: rtl/seq_shift_add_mul.sv
// Bit-serial shift-add multiplier: one bit of b per step, accumulating a<<bit.
module seq_shift_add_mul
  import factor_search_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF,
  parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_step,
  input  logic [A_WIDTH-1:0] i_a,
  input  logic [B_WIDTH-1:0] i_b,
  output logic [P_WIDTH-1:0] o_acc,
  output logic               o_last_bit
);

  localparam int BIT_W = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(B_WIDTH - 1);

  logic [BIT_W-1:0]   r_bit;
  logic [P_WIDTH-1:0] r_acc;
  logic [P_WIDTH-1:0] w_addend;

  always_comb begin
    w_addend = '0;
    if (i_b[r_bit]) w_addend = P_WIDTH'(i_a) << r_bit;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_bit <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_bit <= '0;
    end else if (i_step) begin
      r_acc <= r_acc + w_addend;
      r_bit <= (r_bit == LAST_BIT) ? '0 : r_bit + 1'b1;
    end
  end

  assign o_acc      = r_acc;
  assign o_last_bit = (r_bit == LAST_BIT);

endmodule

// File: rtl/multiplier_factor_search.sv
// Searches b-outer / a-inner for the first nontrivial pair with a*b == latched target.
module multiplier_factor_search
  import factor_search_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF,
  parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [P_WIDTH-1:0] i_target,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_found,
  output logic [A_WIDTH-1:0] o_a_out,
  output logic [B_WIDTH-1:0] o_b_out
);

  localparam logic [A_WIDTH-1:0] A_FIRST = A_WIDTH'(A_MIN);
  localparam logic [B_WIDTH-1:0] B_FIRST = B_WIDTH'(B_MIN);
  localparam logic [A_WIDTH-1:0] A_LAST  = '1;
  localparam logic [B_WIDTH-1:0] B_LAST  = '1;

  state_t             r_state, w_next;
  logic [P_WIDTH-1:0] r_target;
  logic [A_WIDTH-1:0] r_a, r_a_out;
  logic [B_WIDTH-1:0] r_b, r_b_out;
  logic               r_found;
  logic [P_WIDTH-1:0] w_acc;
  logic               w_last_bit, w_clear, w_step;
  logic               w_eq, w_gt, w_a_min, w_a_max, w_b_max, w_stop;

  seq_shift_add_mul #(
    .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .P_WIDTH(P_WIDTH)
  ) u_mul (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_clear),
    .i_step    (w_step),
    .i_a       (r_a),
    .i_b       (r_b),
    .o_acc     (w_acc),
    .o_last_bit(w_last_bit)
  );

  assign w_eq    = (w_acc == r_target);
  assign w_gt    = (w_acc > r_target);
  assign w_a_min = (r_a == A_FIRST);
  assign w_a_max = (r_a == A_LAST);
  assign w_b_max = (r_b == B_LAST);
  // Overshoot at a==2 means every remaining pair (larger b) overshoots too.
  assign w_stop  = w_eq || (w_gt && w_a_min) || ((w_gt || w_a_max) && w_b_max);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    w_step  = 1'b0;
    case (r_state)
      IDLE: if (i_start) w_next = LOAD;
      LOAD: begin
        w_clear = 1'b1;
        w_next  = MUL;
      end
      MUL: begin
        w_step = 1'b1;
        if (w_last_bit) w_next = CMP;
      end
      CMP: begin
        if (w_stop) begin
          w_next = DONE;
        end else begin
          w_clear = 1'b1;
          w_next  = MUL;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_target <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_found  <= 1'b0;
      r_a_out  <= '0;
      r_b_out  <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_target <= i_target;
          r_found  <= 1'b0;
          r_a_out  <= '0;
          r_b_out  <= '0;
        end
        LOAD: begin
          r_a <= A_FIRST;
          r_b <= B_FIRST;
        end
        CMP: begin
          if (w_eq) begin
            r_found <= 1'b1;
            r_a_out <= r_a;
            r_b_out <= r_b;
          end else if (!w_stop) begin
            if (w_gt || w_a_max) begin
              r_b <= r_b + 1'b1;
              r_a <= A_FIRST;
            end else begin
              r_a <= r_a + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy  = (r_state == LOAD) || (r_state == MUL) || (r_state == CMP);
  assign o_done  = (r_state == DONE);
  assign o_found = r_found;
  assign o_a_out = r_a_out;
  assign o_b_out = r_b_out;

endmodule

// File: tb/tb_multiplier_factor_search.sv
// Randomized and directed checks of the factor search against a loop-based reference.
module tb_multiplier_factor_search;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] target;
  logic       busy, done, found;
  logic [4:0] a_out;
  logic [2:0] b_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multiplier_factor_search dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_target(target),
    .o_busy  (busy),
    .o_done  (done),
    .o_found (found),
    .o_a_out (a_out),
    .o_b_out (b_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Enumerates pairs in search order; np counts every pair that gets compared.
  task automatic model(input int t, output bit f, output int fa, output int fb, output int np);
    f = 0; fa = 0; fb = 0; np = 0;
    for (int b = 2; b <= 7; b++) begin
      for (int a = 2; a <= 31; a++) begin
        np++;
        if (a * b == t) begin
          f = 1; fa = a; fb = b;
          return;
        end
        if (a * b > t) begin
          if (a == 2) return;
          break;
        end
      end
    end
  endtask

  task automatic run(input int t, input bit disturb, input string tag);
    bit f;
    int fa, fb, np, n;
    bit got;
    model(t, f, fa, fb, np);
    @(negedge clk);
    target = 8'(t);
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    got = 0;
    while (n < 2000 && !got) begin
      @(posedge clk);
      n++;
      #1;
      if (disturb && n == 8) begin
        target = ~target;
        start  = 1'b1;
      end
      if (disturb && n == 9) start = 1'b0;
      if (done) got = 1;
    end
    check({tag, "_latency"}, 32'(n), 32'(1 + 4 * np));
    check({tag, "_found"}, 32'(found), 32'(f));
    check({tag, "_a"}, 32'(a_out), 32'(fa));
    check({tag, "_b"}, 32'(b_out), 32'(fb));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_held"}, 32'({found, a_out, b_out}), 32'({f, 5'(fa), 3'(fb)}));
  endtask

  initial begin
    int ndone;
    rst_n  = 1'b0;
    start  = 1'b0;
    target = '0;
    #1;
    check("rst_outs", 32'({busy, done, found, a_out, b_out}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(37, 0, "t37");
    run(35, 0, "t35");
    run(2, 0, "t2");
    run(255, 0, "t255");
    run(217, 0, "t217");
    run(0, 0, "t0");
    run(1, 0, "t1");
    run(3, 0, "t3");
    run(35, 1, "t35_disturb");
    for (int i = 0; i < 20; i++) run(int'($urandom_range(0, 255)), 0, "rand");

    run(35, 0, "pre_rst");
    @(negedge clk);
    target = 8'd100;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 target = 8'd77;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (37) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outs", 32'({busy, done, found, a_out, b_out}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    check("midrst_quiet", 32'(ndone), 32'd0);
    run(6, 0, "t6_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
